// File: rtl/mc_chroma_ref_fetch_pkg.sv
// Shared definitions for the chroma reference fetch block.
// Holds the sample/window geometry, the fetch FSM encoding and a small helper
// that maps the block-width field to an effective column count.
package mc_chroma_ref_fetch_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;   // bits per chroma sample
  localparam int unsigned REF_W       = 24;  // samples per reference-window row
  localparam int unsigned REF_H       = 24;  // rows in the reference window
  localparam int unsigned AW          = 5;   // reference-buffer address width
  localparam int unsigned NUM_TAPS    = 4;   // horizontal taps per tap group
  localparam int unsigned XW          = $clog2(REF_W);

  // Rows fetched per column: fractional-y needs the 4-tap vertical support.
  localparam int unsigned RowsFrac = 7;
  localparam int unsigned RowsInt  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fetch_state_e;

  // A zero width field encodes the widest (8-column) block.
  function automatic logic [3:0] eff_width(input logic [3:0] w);
    return (w == 4'd0) ? 4'd8 : w;
  endfunction

endpackage

// File: rtl/mc_chroma_ref_fetch_if.sv
// Signal bundle between the chroma reference fetch, the MC reference buffer
// and the chroma interpolator.
//   block command : start_i, blk_w_i, base_x_i, base_y_i, fracx_i, fracy_i
//   buffer read   : rd_en_o, rd_addr_o, rd_data_i (1-cycle read latency)
//   tap stream    : blk_start_o, fracx_o, fracy_o, ref_valid_o, refuv_p0_o..p3_o
//   status        : busy_o, done_o
// Suffixes are from the fetch block's point of view; 'master' is the fetch
// block, 'slave' is the surrounding environment.
interface mc_chroma_ref_fetch_if;

  logic                                     start_i;
  logic [3:0]                               blk_w_i;
  logic [4:0]                               base_x_i;
  logic [4:0]                               base_y_i;
  logic [2:0]                               fracx_i;
  logic [2:0]                               fracy_i;

  logic                                     rd_en_o;
  logic [mc_chroma_ref_fetch_pkg::AW-1:0]   rd_addr_o;
  logic [mc_chroma_ref_fetch_pkg::REF_W*mc_chroma_ref_fetch_pkg::PIXEL_WIDTH-1:0] rd_data_i;

  logic                                     blk_start_o;
  logic [2:0]                               fracx_o;
  logic [2:0]                               fracy_o;
  logic                                     ref_valid_o;
  logic [mc_chroma_ref_fetch_pkg::PIXEL_WIDTH-1:0] refuv_p0_o;
  logic [mc_chroma_ref_fetch_pkg::PIXEL_WIDTH-1:0] refuv_p1_o;
  logic [mc_chroma_ref_fetch_pkg::PIXEL_WIDTH-1:0] refuv_p2_o;
  logic [mc_chroma_ref_fetch_pkg::PIXEL_WIDTH-1:0] refuv_p3_o;
  logic                                     busy_o;
  logic                                     done_o;

  modport master (
    input  start_i, blk_w_i, base_x_i, base_y_i, fracx_i, fracy_i, rd_data_i,
    output rd_en_o, rd_addr_o, blk_start_o, fracx_o, fracy_o, ref_valid_o,
           refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o, busy_o, done_o
  );

  modport slave (
    output start_i, blk_w_i, base_x_i, base_y_i, fracx_i, fracy_i, rd_data_i,
    input  rd_en_o, rd_addr_o, blk_start_o, fracx_o, fracy_o, ref_valid_o,
           refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o, busy_o, done_o
  );

endinterface

// File: rtl/mc_chroma_tap_sel.sv
// Combinational N-tap extractor: returns NumTaps consecutive samples of a
// packed row, starting at sample index idx_i (sample k at [k*PixW +: PixW]).
//   row_i  : packed row of RowW samples
//   idx_i  : index of the first tap
//   taps_o : taps_o[t] = sample idx_i + t (0 when past the row end)
module mc_chroma_tap_sel #(
  parameter int unsigned PixW    = 8,
  parameter int unsigned RowW    = 24,
  parameter int unsigned NumTaps = 4,
  parameter int unsigned IdxW    = 5
) (
  input  logic [RowW*PixW-1:0]          row_i,
  input  logic [IdxW-1:0]               idx_i,
  output logic [NumTaps-1:0][PixW-1:0]  taps_o
);

  logic [RowW*PixW-1:0] shifted;

  always_comb begin
    shifted = row_i >> (PixW * 32'(idx_i));
    for (int unsigned t = 0; t < NumTaps; t++) begin
      taps_o[t] = shifted[t*PixW +: PixW];
    end
  end

endmodule

// File: rtl/mc_chroma_ref_fetch.sv
// Chroma reference feeder. Reads window rows from the line-organised
// reference buffer and streams 4 horizontal taps per cycle, column-major
// (all rows of column 0, then column 1, ...), to the chroma interpolator.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : command inputs, buffer read port, tap stream and status
//               (see mc_chroma_ref_fetch_if)
module mc_chroma_ref_fetch
  import mc_chroma_ref_fetch_pkg::*;
(
  input logic                   clk,
  input logic                   rstn,
  mc_chroma_ref_fetch_if.master bus
);

  fetch_state_e state_q, state_d;

  // Block parameters captured at start.
  logic [3:0]    w_q;
  logic [2:0]    rows_q;
  logic [XW-1:0] base_x_q;
  logic [AW-1:0] row_base_q;
  logic [2:0]    fracx_q;
  logic [2:0]    fracy_q;

  logic [2:0]    c_q, c_d;
  logic [2:0]    r_q, r_d;
  logic          latch;
  logic          rd_en;
  logic          row_last;
  logic          col_last;

  // Read-return stage: valid and column select travel with the read data.
  logic          blk_start_q;
  logic          valid_q;
  logic [XW-1:0] sel_q;
  logic          done_q;

  logic [NUM_TAPS-1:0][PIXEL_WIDTH-1:0] taps;

  assign rd_en    = (state_q == StRun);
  assign row_last = (r_q == rows_q - 3'd1);
  assign col_last = ({1'b0, c_q} == w_q - 4'd1);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StRun;
          c_d     = 3'd0;
          r_d     = 3'd0;
          latch   = 1'b1;
        end
      end
      StRun: begin
        if (row_last && col_last) begin
          state_d = StDrain;
        end else if (row_last) begin
          r_d = 3'd0;
          c_d = c_q + 3'd1;
        end else begin
          r_d = r_q + 3'd1;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      c_q         <= '0;
      r_q         <= '0;
      w_q         <= '0;
      rows_q      <= '0;
      base_x_q    <= '0;
      row_base_q  <= '0;
      fracx_q     <= '0;
      fracy_q     <= '0;
      blk_start_q <= 1'b0;
      valid_q     <= 1'b0;
      sel_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      blk_start_q <= latch;
      valid_q     <= rd_en;
      // Left tap sits one sample before the column's integer position.
      sel_q       <= rd_en ? (base_x_q + XW'(c_q) - XW'(1)) : '0;
      done_q      <= (state_q == StDrain);
      if (latch) begin
        w_q        <= eff_width(bus.blk_w_i);
        rows_q     <= (bus.fracy_i != 3'd0) ? 3'(RowsFrac) : 3'(RowsInt);
        base_x_q   <= XW'(bus.base_x_i);
        row_base_q <= (bus.fracy_i != 3'd0) ? (AW'(bus.base_y_i) - AW'(1))
                                            : AW'(bus.base_y_i);
        fracx_q    <= bus.fracx_i;
        fracy_q    <= bus.fracy_i;
      end
    end
  end

  mc_chroma_tap_sel #(
    .PixW    (PIXEL_WIDTH),
    .RowW    (REF_W),
    .NumTaps (NUM_TAPS),
    .IdxW    (XW)
  ) u_tap_sel (
    .row_i  (bus.rd_data_i),
    .idx_i  (sel_q),
    .taps_o (taps)
  );

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = rd_en ? (row_base_q + AW'(r_q)) : '0;
  assign bus.blk_start_o = blk_start_q;
  assign bus.fracx_o     = fracx_q;
  assign bus.fracy_o     = fracy_q;
  assign bus.ref_valid_o = valid_q;
  assign bus.refuv_p0_o  = valid_q ? taps[0] : '0;
  assign bus.refuv_p1_o  = valid_q ? taps[1] : '0;
  assign bus.refuv_p2_o  = valid_q ? taps[2] : '0;
  assign bus.refuv_p3_o  = valid_q ? taps[3] : '0;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_mc_chroma_ref_fetch.sv
// Bench for mc_chroma_ref_fetch: reference window pixel(x,y) = (x + 16*y) mod 256.
module tb_mc_chroma_ref_fetch;
  import mc_chroma_ref_fetch_pkg::*;

  typedef struct packed {
    logic [2:0] fx;
    logic [2:0] fy;
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] p0;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t        exp_q[$];
  logic [4:0]  exp_addr_q[$];
  logic [5:0]  exp_blk_q[$];

  mc_chroma_ref_fetch_if bus ();

  mc_chroma_ref_fetch dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'((x + 16 * y) & 255);
  endfunction

  // Reference buffer model: 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      for (int k = 0; k < int'(REF_W); k++) begin
        bus.rd_data_i[k*8 +: 8] <= pix(k, int'(bus.rd_addr_o));
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {16'd0, bus.rd_en_o, bus.rd_addr_o, bus.blk_start_o, bus.fracx_o, bus.fracy_o,
            bus.ref_valid_o, bus.refuv_p0_o, bus.refuv_p1_o, bus.refuv_p2_o, bus.refuv_p3_o,
            bus.busy_o, bus.done_o};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rd_en_o) begin
        if (exp_addr_q.size() == 0) check("rd_addr_unexpected", 1, 0);
        else check("rd_addr", bus.rd_addr_o, exp_addr_q.pop_front());
      end
      if (bus.blk_start_o) begin
        if (exp_blk_q.size() == 0) check("blk_start_unexpected", 1, 0);
        else check("blk_start_frac_novalid",
                   {bus.ref_valid_o, bus.fracx_o, bus.fracy_o, bus.refuv_p0_o, bus.refuv_p1_o,
                    bus.refuv_p2_o, bus.refuv_p3_o},
                   {1'b0, exp_blk_q.pop_front(), 32'd0});
      end
      if (bus.ref_valid_o) begin
        if (exp_q.size() == 0) check("taps_unexpected", 1, 0);
        else check("taps_frac",
                   {bus.fracx_o, bus.fracy_o, bus.refuv_p3_o, bus.refuv_p2_o, bus.refuv_p1_o,
                    bus.refuv_p0_o}, exp_q.pop_front());
      end
    end
  end

  task automatic push_block(input int w_in, input int bx, input int by, input int fx,
                            input int fy);
    int w, rr, rb;
    exp_t e;
    w  = (w_in == 0) ? 8 : w_in;
    rr = (fy != 0) ? 7 : 4;
    rb = (fy != 0) ? by - 1 : by;
    exp_blk_q.push_back({3'(fx), 3'(fy)});
    for (int c = 0; c < w; c++) begin
      for (int r = 0; r < rr; r++) begin
        exp_addr_q.push_back(5'(rb + r));
        e.fx = 3'(fx);
        e.fy = 3'(fy);
        e.p0 = pix(bx + c - 1, rb + r);
        e.p1 = pix(bx + c,     rb + r);
        e.p2 = pix(bx + c + 1, rb + r);
        e.p3 = pix(bx + c + 2, rb + r);
        e.p0 = e.p0; // keep struct fully assigned before push
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_cmd(input int w_in, input int bx, input int by, input int fx,
                           input int fy);
    bus.start_i  = 1'b1;
    bus.blk_w_i  = 4'(w_in);
    bus.base_x_i = 5'(bx);
    bus.base_y_i = 5'(by);
    bus.fracx_i  = 3'(fx);
    bus.fracy_i  = 3'(fy);
  endtask

  // Issue one block at the current negedge and follow it until done_o.
  // restart_at > 0 pulses start_i again (with different fields) that many
  // cycles into the block.
  task automatic run_block(input string tag, input int w_in, input int bx, input int by,
                           input int fx, input int fy, input int restart_at);
    int w, rr, t0, n, nvalid, start_at, done_at, rise_at, fall_at;
    logic busy_prev;
    w  = (w_in == 0) ? 8 : w_in;
    rr = (fy != 0) ? 7 : 4;
    push_block(w_in, bx, by, fx, fy);
    drive_cmd(w_in, bx, by, fx, fy);
    t0 = cyc;
    n = 0; nvalid = 0; start_at = -1; done_at = -1; rise_at = -1; fall_at = -1;
    busy_prev = bus.busy_o;
    do begin
      @(negedge clk);
      n++;
      bus.start_i = (n == restart_at);
      if (n == restart_at) begin
        bus.blk_w_i = 4'd1;
        bus.fracx_i = 3'(fx + 1);
        bus.fracy_i = 3'(fy + 1);
      end
      if (bus.blk_start_o && start_at < 0) start_at = cyc;
      if (bus.ref_valid_o) nvalid++;
      if (bus.busy_o && !busy_prev && rise_at < 0) rise_at = cyc;
      if (!bus.busy_o && busy_prev && fall_at < 0) fall_at = cyc;
      busy_prev = bus.busy_o;
      if (bus.done_o) done_at = cyc;
    end while (done_at < 0 && n < 200);
    bus.start_i = 1'b0;
    check({tag, "_blk_start_at"}, start_at - t0, 1);
    check({tag, "_valid_count"}, nvalid, w * rr);
    check({tag, "_done_at"}, done_at - t0, 2 + w * rr);
    check({tag, "_busy_rise"}, rise_at - t0, 1);
    check({tag, "_busy_fall"}, fall_at - t0, 2 + w * rr);
  endtask

  initial begin
    bit done_seen;
    bus.start_i   = 1'b0;
    bus.blk_w_i   = '0;
    bus.base_x_i  = '0;
    bus.base_y_i  = '0;
    bus.fracx_i   = '0;
    bus.fracy_i   = '0;
    bus.rd_data_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_block("b4_int",  4, 4, 4, 3, 0, 0);
    repeat (3) @(negedge clk);
    run_block("b4_frac", 4, 4, 4, 1, 5, 0);
    repeat (3) @(negedge clk);
    run_block("b8_w0",   0, 2, 10, 6, 2, 0);
    repeat (3) @(negedge clk);
    run_block("mid_start", 3, 5, 1, 2, 0, 5);
    repeat (3) @(negedge clk);

    // Reset in the middle of a block.
    push_block(4, 6, 8, 5, 3);
    drive_cmd(4, 6, 8, 5, 3);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    #1 rstn = 1'b0;
    #1 check("midrst_outputs", outs_vec(), 0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_blk_q.delete();
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen |= bus.done_o;
    end
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      done_seen |= bus.done_o | bus.busy_o;
    end
    check("midrst_no_done", done_seen, 0);

    run_block("after_rst", 2, 1, 17, 4, 7, 0);
    repeat (3) @(negedge clk);

    // Back-to-back: each next start is driven on the previous done_o cycle.
    run_block("b2b_a", 4, 3, 2, 2, 0, 0);
    run_block("b2b_b", 4, 8, 12, 5, 0, 0);
    run_block("b2b_c", 4, 10, 6, 7, 3, 0);
    repeat (4) @(negedge clk);

    check("sb_taps_left", exp_q.size(), 0);
    check("sb_addr_left", exp_addr_q.size(), 0);
    check("sb_blk_left", exp_blk_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
